// File: rtl/bar_bin_pkg.sv
// Shared types and constant tables for the bar bin sequencer: FSM states,
// log-spaced bin map and per-bar reciprocals used to average each bar.
package bar_bin_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StDrain,
        StScale,
        StCommit
    } state_e;

    localparam int unsigned NUM_BARS = 16;
    // Sized for the default WIDTH of 12: worst case 32 bins of 14 bits.
    localparam int unsigned ACC_W    = 20;
    localparam int unsigned RECIP_W  = 17;
    localparam int unsigned CNT_W    = 6;

    localparam logic [7:0] BIN_START [NUM_BARS] = '{
        8'd0,  8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd7,  8'd9,
        8'd13, 8'd17, 8'd25, 8'd33, 8'd45, 8'd57, 8'd73, 8'd97
    };

    localparam logic [CNT_W-1:0] BIN_COUNT [NUM_BARS] = '{
        6'd1, 6'd1, 6'd1,  6'd1,  6'd1,  6'd2,  6'd2,  6'd4,
        6'd4, 6'd8, 6'd8,  6'd12, 6'd12, 6'd16, 6'd24, 6'd32
    };

    // ceil(65536 / count): exact for sums that are whole multiples of count.
    localparam logic [RECIP_W-1:0] RECIP [NUM_BARS] = '{
        17'd65536, 17'd65536, 17'd65536, 17'd65536,
        17'd65536, 17'd32768, 17'd32768, 17'd16384,
        17'd16384, 17'd8192,  17'd8192,  17'd5462,
        17'd5462,  17'd4096,  17'd2731,  17'd2048
    };

endpackage

// File: rtl/bar_bin_sequencer_if.sv
// FFT buffer side of the sequencer: new-bins pulse, single read port and the
// lock that keeps the FFT from overwriting bins during a pass.
interface bar_bin_sequencer_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 14
);
    logic              fft_done;
    logic [ADDR_W-1:0] bin_addr;
    logic [DATA_W-1:0] bin_data;
    logic              sample_lock;

    modport master (
        input  fft_done,
        input  bin_data,
        output bin_addr,
        output sample_lock
    );

    modport slave (
        output fft_done,
        output bin_data,
        input  bin_addr,
        input  sample_lock
    );
endinterface

// File: rtl/bar_scale_sat.sv
// Average one bar's accumulated sum with a reciprocal multiply and clamp the
// result to the screen height. Purely combinational.
module bar_scale_sat
    import bar_bin_pkg::*;
#(
    parameter int unsigned HW         = 5,
    parameter int unsigned MAX_HEIGHT = 30
) (
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [RECIP_W-1:0] recip_i,
    output logic [HW-1:0]      height_o
);
    localparam int unsigned ProdW = ACC_W + RECIP_W;
    localparam int unsigned AvgW  = ProdW - 16;

    logic [ProdW-1:0] prod;
    logic [AvgW-1:0]  avg;

    assign prod     = ProdW'(acc_i) * ProdW'(recip_i);
    assign avg      = AvgW'(prod >> 16);
    assign height_o = (avg > AvgW'(MAX_HEIGHT)) ? HW'(MAX_HEIGHT) : avg[HW-1:0];
endmodule

// File: rtl/bar_bin_sequencer.sv
// Time-multiplexed bar summer: one bin per cycle into 16 log-spaced bars, committed at vsync.
// Optional build macro BAR_PEAK_DECAY_EN enables a falling peak-hold on commit.
module bar_bin_sequencer
    import bar_bin_pkg::*;
#(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned N          = 256,
    parameter int unsigned BARS       = 16,
    parameter int unsigned MAX_HEIGHT = 30,
    parameter int unsigned HW         = 5,
    parameter int unsigned DECAY      = 1,
    localparam int unsigned ADDR_W    = $clog2(N)
) (
    input  logic                     clk_25MHz,
    input  logic                     rst_n,
    input  logic                     vsync,
    input  logic [3:0]               shift,
    output logic                     busy,
    output logic [BARS-1:0][HW-1:0]  bars,
    output logic                     bars_valid,
    bar_bin_sequencer_if.master      bin_if
);
    localparam int unsigned BarW = $clog2(BARS);

    state_e                   state_q, state_d;
    logic [BarW-1:0]          bar_q, bar_d;
    logic [CNT_W-1:0]         k_q, k_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [BARS-1:0][HW-1:0]  shadow_q, shadow_d;
    logic [BARS-1:0][HW-1:0]  bars_q, bars_d;
    logic                     bars_valid_q, bars_valid_d;
    logic                     pending_q, pending_d;
    logic [1:0]               vs_q, vs_d;

    logic [WIDTH+1:0]         sample_raw;
    logic [ACC_W-1:0]         sample;
    logic                     start;
    logic [HW-1:0]            scaled;
    logic [HW-1:0]            commit_val;

    assign sample_raw = bin_if.bin_data >> shift;
    assign sample     = ACC_W'(sample_raw);
    assign start      = (state_q == StIdle) && vs_q[0] && !vs_q[1] && pending_q;
    assign vs_d       = {vs_q[0], vsync};
    assign pending_d  = (pending_q && !start) || bin_if.fft_done;

    bar_scale_sat #(
        .HW         (HW),
        .MAX_HEIGHT (MAX_HEIGHT)
    ) u_scale (
        .acc_i    (acc_q),
        .recip_i  (RECIP[bar_q]),
        .height_o (scaled)
    );

`ifdef BAR_PEAK_DECAY_EN
    logic [HW-1:0] prev_decayed;
    // Compare against the committed bar so the peak falls once per frame.
    assign prev_decayed = (bars_q[bar_q] > HW'(DECAY)) ? bars_q[bar_q] - HW'(DECAY) : '0;
    assign commit_val   = (scaled > prev_decayed) ? scaled : prev_decayed;
`else
    logic unused_decay;
    assign unused_decay = ^DECAY;
    assign commit_val   = scaled;
`endif

    always_comb begin
        state_d      = state_q;
        bar_d        = bar_q;
        k_d          = k_q;
        acc_d        = acc_q;
        shadow_d     = shadow_q;
        bars_d       = bars_q;
        bars_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                    bar_d   = '0;
                    k_d     = '0;
                end
            end
            StAccum: begin
                // Data arrives one cycle after its address, so k=0 only clears.
                acc_d = (k_q == '0) ? '0 : acc_q + sample;
                if (k_q == BIN_COUNT[bar_q] - CNT_W'(1)) begin
                    state_d = StDrain;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            StDrain: begin
                acc_d   = acc_q + sample;
                state_d = StScale;
            end
            StScale: begin
                shadow_d[bar_q] = commit_val;
                k_d             = '0;
                if (bar_q == BarW'(BARS - 1)) begin
                    state_d = StCommit;
                end else begin
                    bar_d   = bar_q + BarW'(1);
                    state_d = StAccum;
                end
            end
            StCommit: begin
                bars_d       = shadow_q;
                bars_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bar_q        <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            shadow_q     <= '0;
            bars_q       <= '0;
            bars_valid_q <= 1'b0;
            pending_q    <= 1'b0;
            vs_q         <= '0;
        end else begin
            state_q      <= state_d;
            bar_q        <= bar_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            shadow_q     <= shadow_d;
            bars_q       <= bars_d;
            bars_valid_q <= bars_valid_d;
            pending_q    <= pending_d;
            vs_q         <= vs_d;
        end
    end

    assign bin_if.bin_addr    = (state_q == StAccum) ?
                                ADDR_W'(BIN_START[bar_q]) + ADDR_W'(k_q) : '0;
    assign busy               = (state_q != StIdle);
    assign bin_if.sample_lock = busy;
    assign bars               = bars_q;
    assign bars_valid         = bars_valid_q;
endmodule

// File: tb/tb_bar_bin_sequencer.sv
// Bench for bar_bin_sequencer: directed frames with literal expectations plus
// random vsync/fft_done traffic checked every cycle against a frame-level model.
module tb_bar_bin_sequencer;
    localparam int PASS_LEN = 162;
    localparam int NB       = 16;
    localparam int MAXH     = 30;
`ifdef BAR_PEAK_DECAY_EN
    localparam int DECAY    = 1;
`endif

    logic                 clk_25MHz = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 vsync     = 1'b0;
    logic [3:0]           shift     = 4'd0;
    logic                 busy;
    logic [NB-1:0][4:0]   bars;
    logic                 bars_valid;

    bar_bin_sequencer_if #(.ADDR_W(8), .DATA_W(14)) bif ();

    bar_bin_sequencer #(
        .WIDTH      (12),
        .N          (256),
        .BARS       (16),
        .MAX_HEIGHT (30),
        .HW         (5),
        .DECAY      (1)
    ) dut (
        .clk_25MHz  (clk_25MHz),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .shift      (shift),
        .busy       (busy),
        .bars       (bars),
        .bars_valid (bars_valid),
        .bin_if     (bif)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    logic [13:0] mem [256];
    always @(posedge clk_25MHz) bif.bin_data <= mem[bif.bin_addr];

    int bin_start [NB] = '{0, 1, 2, 3, 4, 5, 7, 9, 13, 17, 25, 33, 45, 57, 73, 97};
    int bin_count [NB] = '{1, 1, 1, 1, 1, 2, 2, 4, 4, 8, 8, 12, 12, 16, 24, 32};
    int exp_addr [PASS_LEN];

    int vectors     = 0;
    int miscompares = 0;
    int valid_seen  = 0;

    // Frame-level model: pass length countdown, pending flag, vsync history.
    int m_rem     = 0;
    bit m_pending = 1'b0;
    bit m_prev1   = 1'b0;
    bit m_prev2   = 1'b0;
    bit m_valid   = 1'b0;
    int m_bars [NB];
    int m_next [NB];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void compute_next();
        for (int b = 0; b < NB; b++) begin
            longint sum;
            longint recip;
            longint avg;
            sum = 0;
            for (int k = 0; k < bin_count[b]; k++) sum += longint'(mem[bin_start[b] + k] >> shift);
            recip = (65536 + bin_count[b] - 1) / bin_count[b];
            avg   = (sum * recip) >> 16;
            if (avg > MAXH) avg = MAXH;
`ifdef BAR_PEAK_DECAY_EN
            if (m_bars[b] - DECAY > avg) avg = m_bars[b] - DECAY;
`endif
            m_next[b] = int'(avg);
        end
    endfunction

    function automatic logic [79:0] all_bars(input int v);
        logic [79:0] r;
        for (int b = 0; b < NB; b++) r[b*5 +: 5] = 5'(v);
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk_25MHz);
            m_valid = 1'b0;
            if (!rst_n) begin
                m_rem = 0; m_pending = 1'b0; m_prev1 = 1'b0; m_prev2 = 1'b0;
                for (int b = 0; b < NB; b++) m_bars[b] = 0;
            end else begin
                bit trig;
                trig = (m_rem == 0) && m_pending && m_prev1 && !m_prev2;
                if (trig) begin
                    compute_next();
                    m_rem = PASS_LEN;
                end else if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        for (int b = 0; b < NB; b++) m_bars[b] = m_next[b];
                        m_valid = 1'b1;
                    end
                end
                m_pending = (m_pending && !trig) || bif.fft_done;
                m_prev2   = m_prev1;
                m_prev1   = vsync;
            end
        end
    end

    initial begin
        forever begin
            logic [79:0] eb;
            @(posedge clk_25MHz);
            #1;
            for (int b = 0; b < NB; b++) eb[b*5 +: 5] = 5'(m_bars[b]);
            check("busy", busy, (m_rem > 0) ? 1'b1 : 1'b0);
            check("sample_lock", bif.sample_lock, (m_rem > 0) ? 1'b1 : 1'b0);
            check("bars_valid", bars_valid, m_valid);
            check("bars", bars, eb);
            if (m_rem > 0 && exp_addr[PASS_LEN - m_rem] >= 0)
                check("bin_addr", bif.bin_addr, 128'(exp_addr[PASS_LEN - m_rem]));
            if (bars_valid === 1'b1) valid_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_25MHz);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 256; i++) mem[i] = 14'(v);
    endtask

    task automatic pulse_fft();
        bif.fft_done = 1'b1;
        tick(1);
        bif.fft_done = 1'b0;
    endtask

    task automatic wait_busy(output bit ok);
        int w;
        w = 0;
        while (!busy && w < 10) begin tick(1); w++; end
        ok = busy;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 400) begin n++; tick(1); end
    endtask

    task automatic run_frame(output int blen, output int vpulses);
        int v0;
        bit ok;
        v0 = valid_seen;
        pulse_fft();
        tick(1);
        vsync = 1'b1;
        wait_busy(ok);
        count_busy(blen);
        vsync = 1'b0;
        tick(3);
        vpulses = valid_seen - v0;
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int blen, vc, bcnt, v0, w;
        bit ok;
        logic [79:0] e;
        bif.fft_done = 1'b0;
        fill(0);
        for (int b = 0; b < NB; b++) begin m_bars[b] = 0; m_next[b] = 0; end
        begin
            int idx;
            idx = 0;
            for (int b = 0; b < NB; b++) begin
                for (int k = 0; k < bin_count[b]; k++) begin exp_addr[idx] = bin_start[b] + k; idx++; end
                exp_addr[idx] = -1; exp_addr[idx + 1] = -1; idx += 2;
            end
            exp_addr[idx] = -1;
        end
        tick(3);
        check("reset_bars", bars, 80'd0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick(2);

`ifdef BAR_PEAK_DECAY_EN
        fill(80); shift = 4'd2;
        run_frame(blen, vc);
        check("decay_busy_len", blen, PASS_LEN);
        check("decay_valid_pulses", vc, 1);
        check("decay_first", bars, all_bars(20));
        fill(0);
        for (int f = 1; f <= 22; f++) begin
            run_frame(blen, vc);
            check("decay_step", bars, all_bars((20 - f > 0) ? 20 - f : 0));
        end
`else
        fill(64); shift = 4'd2;
        run_frame(blen, vc);
        check("flat64_busy_len", blen, PASS_LEN);
        check("flat64_valid_pulses", vc, 1);
        check("flat64_bars", bars, all_bars(16));

        fill(0);
        for (int i = 33; i <= 44; i++) mem[i] = 14'd10;
        shift = 4'd0;
        run_frame(blen, vc);
        e = '0;
        e[11*5 +: 5] = 5'd10;
        check("bar11_only", bars, e);

        fill(1000);
        run_frame(blen, vc);
        check("saturate_bars", bars, all_bars(30));
`endif

        // vsync rise without a pending frame must not start a pass.
        bcnt = 0;
        vsync = 1'b1;
        repeat (12) begin tick(1); if (busy) bcnt++; end
        vsync = 1'b0;
        tick(2);
        check("no_pending_busy", bcnt, 0);

        // fft_done and a fresh vsync rise while busy: rise ignored, pending kept.
        pulse_fft();
        tick(1);
        vsync = 1'b1;
        wait_busy(ok);
        check("pass_started", ok, 1'b1);
        tick(10);
        pulse_fft();
        tick(10);
        vsync = 1'b0;
        tick(3);
        vsync = 1'b1;
        count_busy(blen);
        bcnt = 0;
        repeat (20) begin tick(1); if (busy) bcnt++; end
        check("rise_in_busy_ignored", bcnt, 0);
        vsync = 1'b0;
        tick(2);
        vsync = 1'b1;
        wait_busy(ok);
        count_busy(blen);
        check("deferred_pass_len", blen, PASS_LEN);
        vsync = 1'b0;
        tick(3);

        // Reset in the middle of a pass aborts without a commit.
        pulse_fft();
        tick(1);
        vsync = 1'b1;
        wait_busy(ok);
        tick(79);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 1'b0);
        check("midreset_bars", bars, 80'd0);
        check("midreset_valid", bars_valid, 1'b0);
        tick(2);
        rst_n = 1'b1;
        v0 = valid_seen;
        bcnt = 0;
        vsync = 1'b0;
        repeat (200) begin tick(1); if (busy) bcnt++; end
        check("after_reset_busy", bcnt, 0);
        check("after_reset_valid", valid_seen - v0, 0);

        // Random traffic: bins and shift only change while idle.
        for (int f = 0; f < 6; f++) begin
            int maxv;
            vsync = 1'b0;
            bif.fft_done = 1'b0;
            w = 0;
            while (busy && w < 400) begin tick(1); w++; end
            check("idle_before_load", busy, 1'b0);
            maxv = (1 << $urandom_range(4, 14)) - 1;
            for (int i = 0; i < 256; i++) mem[i] = 14'($urandom_range(0, maxv));
            shift = 4'($urandom_range(0, (f < 4) ? 4 : 15));
            repeat (800) begin
                bif.fft_done = !bif.fft_done && ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 29) == 0) vsync = ~vsync;
                tick(1);
            end
        end
        bif.fft_done = 1'b0;
        vsync = 1'b0;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bar_bin_sequencer.md
Name: bar_bin_sequencer

Overview:
- Time-multiplexed replacement for the wide combinational bin-summing tree in the graphics path.
- Once per frame, after a completed FFT, reads the magnitude bins one per cycle through a single read port. Each bin is right-shifted by the user shift value (switches[3:0]).
- Bins are grouped into 16 log-spaced bars, averaged with one shared multiplier and saturated to screen height.
- All bars are committed atomically at the vsync rising edge, which removes tearing. Sits between the FFT output buffer and the VGA bar renderer.

Parameters:
- WIDTH, 12, FFT magnitude base width; bin_data is WIDTH+2 bits.
- N, 256, number of FFT bins; ADDR_W = $clog2(N).
- BARS, 16, number of output bars; the bin map table is sized for 16.
- MAX_HEIGHT, 30, bar saturation value in character rows.
- HW, 5, bar height width; must satisfy 2^HW > MAX_HEIGHT.
- DECAY, 1, peak-hold decay per frame (used only with the optional feature).

Ports:
- clk_25MHz  in  1  pixel/system clock
- rst_n  in  1  asynchronous active-low reset
- fft_done  in  1  one-cycle pulse: new bins valid in the FFT buffer
- vsync  in  1  VGA vsync level; the rising edge is detected internally
- shift  in  4  right shift applied to every bin (switches[3:0])
- bin_addr  out  ADDR_W  bin read address
- bin_data  in  WIDTH+2  bin magnitude, valid 1 cycle after bin_addr
- sample_lock  out  1  high while busy; the FFT must not overwrite bins
- busy  out  1  pass in progress
- bars  out  BARS x HW  committed bar heights
- bars_valid  out  1  one-cycle pulse on commit

Behaviour:
- Reset: bars all 0, busy/sample_lock/bars_valid 0, bin_addr 0, pending 0, state IDLE, vsync edge register 0.
- fft_done sets pending; pending is cleared when a pass starts. fft_done during busy sets pending for the next frame.
- Trigger: vsync rising edge (registered 2-stage edge detect) AND pending. Edges while busy, or without pending, are ignored and bars hold.
- Bin map (start, count) per bar 0..15:
  (0,1)(1,1)(2,1)(3,1)(4,1)(5,2)(7,2)(9,4)(13,4)(17,8)(25,8)(33,12)(45,12)(57,16)(73,24)(97,32).
  The map covers bins 0..128.
- FSM:
  - IDLE -> ACCUM on trigger.
  - ACCUM: issue bin_addr = start+k for k = 0..count-1, one per cycle. Accumulation lags one cycle (read latency).
  - DRAIN: 1 cycle, adds the last sample.
  - SCALE: 1 cycle, writes shadow[bar]. Then goes to ACCUM of the next bar, or to COMMIT after bar 15.
  - COMMIT: 1 cycle, bars <= shadow, bars_valid pulses the next cycle, then IDLE.
  - busy spans the sum of (count+2) plus 1 = 162 cycles.
- Arithmetic:
  - Sample = bin_data >> shift, unsigned, full WIDTH+2 bits with no truncation.
  - Accumulator is WIDTH+8 bits and is cleared at each bar start.
  - Average = (acc * RECIP[bar]) >> 16, where RECIP = ceil(65536/count) as 17-bit constants. This is exact for multiples of count, and the error is negligible below MAX_HEIGHT.
  - Result is saturated to MAX_HEIGHT.
- Shadow registers are written only during a pass, so the displayed bars never change mid-frame.
- rst_n asserted mid-pass: immediate abort to reset values, with no commit.

Optional Feature:
- Macro: BAR_PEAK_DECAY_EN.
- Defined: commit value = max(new, prev - DECAY), floored at 0, giving a falling peak-hold per frame.
- Undefined: commit value = new. No prev-compare logic is instantiated.

Decomposition:
- Package bar_bin_pkg holds:
  - state enum (IDLE, ACCUM, DRAIN, SCALE, COMMIT);
  - BIN_START, BIN_COUNT and RECIP constant arrays;
  - ACC_W localparam.
- One sub-module: bar_scale_sat. Combinational multiply, shift and saturate; reused per bar in SCALE.

Test Plan:
- All bins = 64, shift = 2, fft_done, then vsync rise: busy for 162 cycles, then bars all 16 and one bars_valid pulse.
- Bins 33..44 = 10, others 0, shift 0: bar11 = 10; all other bars 0 except bar10, which is 0 because it covers 25..32.
- All bins = 1000, shift 0: every bar saturates to 30.
- vsync rise with no prior fft_done: no busy, bars unchanged. A second vsync rise during busy is ignored. fft_done during busy causes a pass on the following vsync.
- rst_n low at cycle 80 of a pass: bars 0, busy 0 at once, and no bars_valid.
- With BAR_PEAK_DECAY_EN and DECAY = 1: frame 1 all bins = 80 with shift 2 gives bars 20. Zero bins on subsequent frames give 19, 18, and so on down to 0, then stay at 0.
